// File: rtl/iiitb_pdet_pkg.sv
// iiitb_pdet_pkg: shared definitions for the programmable serial pattern detector.
//   - state_e     : FSM state encoding (IDLE = 1'b0, RUN = 1'b1)
//   - len_width() : width of a field able to hold 0..max_len
//   - MAX_LEN_MIN / MAX_LEN_MAX : legal range of the MAX_LEN parameter
package iiitb_pdet_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int MAX_LEN_MIN = 2;
    localparam int MAX_LEN_MAX = 32;

    // Bits needed to encode the values 0..max_len inclusive.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/iiitb_pdet_if.sv
// iiitb_pdet_if: bundles the configuration, data and status signals of iiitb_pdet.
//   master modport : drives cfg_*, in_valid, sequence_in, cnt_clr; observes status
//   slave  modport : the detector itself
//   Parameters MAX_LEN / CNT_W must match the ones given to iiitb_pdet.
interface iiitb_pdet_if
    import iiitb_pdet_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = len_width(MAX_LEN);

    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               sequence_in;
    logic               cnt_clr;
    logic               detector_out;
    logic [CNT_W-1:0]   match_count;
    logic               armed;
    logic               cfg_err;
    logic               io_oeb;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, sequence_in, cnt_clr,
        input  detector_out, match_count, armed, cfg_err, io_oeb
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, sequence_in, cnt_clr,
        output detector_out, match_count, armed, cfg_err, io_oeb
    );

endinterface

// File: rtl/iiitb_pdet_cnt.sv
// iiitb_pdet_cnt: CNT_W-bit saturating match counter.
//   clock, reset (async, active-high)
//   clr_i   : synchronous clear; combined with inc_i the result is 1
//   inc_i   : increment request, holds at all-ones instead of wrapping
//   count_o : registered count
module iiitb_pdet_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear first, then apply a saturating increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = inc_i ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/iiitb_pdet.sv
// iiitb_pdet: run-time programmable serial pattern detector.
//   clock : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : iiitb_pdet_if.slave (config strobe + pattern/len/overlap, qualified
//           serial input, counter clear, match pulse, match count, armed,
//           cfg_err, io_oeb)
// Build option: define IIITB_PDET_CNT_EN to build the saturating match counter;
// otherwise match_count is tied to 0 and cnt_clr is ignored.
module iiitb_pdet
    import iiitb_pdet_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    iiitb_pdet_if.slave bus
);
    localparam int LEN_W = len_width(MAX_LEN);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               err_q, err_d;
    logic               det_q;

    logic               cfg_ok_s;
    logic               fill_ok_s;
    logic [MAX_LEN-1:0] cand_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               match_s;

    // Match evaluation on the incoming bit, against the newest len bits of history.
    always_comb begin
        cfg_ok_s  = (bus.cfg_len != {LEN_W{1'b0}}) && (bus.cfg_len <= LEN_W'(MAX_LEN));
        cand_s    = {hist_q[MAX_LEN-2:0], bus.sequence_in};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (LEN_W'(i) < len_q);
        end
        // One extra bit so fill+1 cannot wrap when fill == MAX_LEN.
        fill_ok_s = (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q});
        match_s   = (state_q == ST_RUN) && bus.in_valid && !bus.cfg_we && fill_ok_s &&
                    ((cand_s & mask_s) == (pat_q & mask_s));
    end

    // FSM next state, history/fill update and config latching; config beats data.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        err_d   = err_q;
        if (bus.cfg_we) begin
            pat_d  = bus.cfg_pattern;
            len_d  = bus.cfg_len;
            ovl_d  = bus.cfg_overlap;
            hist_d = {MAX_LEN{1'b0}};
            fill_d = {LEN_W{1'b0}};
            if (cfg_ok_s) begin
                state_d = ST_RUN;
                err_d   = 1'b0;
            end else begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.in_valid) begin
                        hist_d = cand_s;
                        if (fill_q < LEN_W'(MAX_LEN)) begin
                            fill_d = fill_q + {{(LEN_W-1){1'b0}}, 1'b1};
                        end else begin
                            fill_d = fill_q;
                        end
                        // Non-overlap: the next match must be built from fresh bits.
                        if (match_s && !ovl_q) begin
                            fill_d = {LEN_W{1'b0}};
                        end else begin
                            fill_d = fill_d;
                        end
                    end else begin
                        hist_d = hist_q;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, history, stored config and registered match pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hist_q  <= {MAX_LEN{1'b0}};
            fill_q  <= {LEN_W{1'b0}};
            pat_q   <= {MAX_LEN{1'b0}};
            len_q   <= {LEN_W{1'b0}};
            ovl_q   <= 1'b0;
            err_q   <= 1'b0;
            det_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            err_q   <= err_d;
            det_q   <= match_s;
        end
    end

    assign bus.detector_out = det_q;
    assign bus.armed        = (state_q == ST_RUN);
    assign bus.cfg_err      = err_q;
    assign bus.io_oeb       = 1'b0;

`ifdef IIITB_PDET_CNT_EN
    iiitb_pdet_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (bus.cnt_clr),
        .inc_i   (match_s),
        .count_o (bus.match_count)
    );
`else
    assign bus.match_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_iiitb_pdet.sv
// Self-checking bench for iiitb_pdet (MAX_LEN = 8, CNT_W = 2).
module tb_iiitb_pdet;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;

    typedef struct packed {
        logic             det;
        logic [CNT_W-1:0] cnt;
        logic             armed;
        logic             err;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    iiitb_pdet_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    iiitb_pdet #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int npulse;
    exp_t exp_q[$];

    // Reference model state.
    logic        m_run, m_err, m_ov;
    logic [7:0]  m_pat;
    int          m_len, m_fill, m_cnt;
    logic [31:0] m_hist;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_err = 1'b0; m_ov = 1'b0; m_pat = 8'd0;
        m_len = 0; m_fill = 0; m_cnt = 0; m_hist = 32'd0;
    endtask

    // One clock: drive inputs, push model prediction, compare after the edge.
    task automatic drive(input logic we, input logic [7:0] pat, input logic [3:0] len,
                         input logic ov, input logic v, input logic b, input logic clr);
        exp_t e;
        logic        det;
        logic [31:0] cand, mask;
        @(negedge clock);
        bus.cfg_we = we; bus.cfg_pattern = pat; bus.cfg_len = len; bus.cfg_overlap = ov;
        bus.in_valid = v; bus.sequence_in = b; bus.cnt_clr = clr;
        det = 1'b0;
        if (we) begin
            m_pat = pat; m_len = int'(len); m_ov = ov; m_hist = 32'd0; m_fill = 0;
            if (len >= 4'd1 && len <= 4'd8) begin m_run = 1'b1; m_err = 1'b0; end
            else begin m_run = 1'b0; m_err = 1'b1; end
        end else if (m_run && v) begin
            cand = {m_hist[30:0], b};
            mask = (32'd1 << m_len) - 32'd1;
            det  = (m_fill + 1 >= m_len) && ((cand & mask) == ({24'd0, m_pat} & mask));
            m_hist = cand;
            m_fill = (m_fill + 1 > MAX_LEN) ? MAX_LEN : m_fill + 1;
            if (det && !m_ov) m_fill = 0;
        end
`ifdef IIITB_PDET_CNT_EN
        if (clr) m_cnt = 0;
        if (det && m_cnt < 3) m_cnt++;
`else
        m_cnt = 0;
`endif
        e.det = det; e.cnt = CNT_W'(m_cnt); e.armed = m_run; e.err = m_err;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check_val("det",   32'(bus.detector_out), 32'(e.det));
        check_val("count", 32'(bus.match_count),  32'(e.cnt));
        check_val("armed", 32'(bus.armed),        32'(e.armed));
        check_val("err",   32'(bus.cfg_err),      32'(e.err));
        if (bus.detector_out) npulse++;
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov);
        drive(1'b1, pat, len, ov, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic bit_in(input logic b);
        drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, b, 1'b0);
    endtask
    task automatic gap();
        drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic clr_cnt();
        drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask
    task automatic stream(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
    endtask
    task automatic check_all_zero(input string tag);
        check_val({tag, "_det"},   32'(bus.detector_out), 32'd0);
        check_val({tag, "_cnt"},   32'(bus.match_count),  32'd0);
        check_val({tag, "_armed"}, 32'(bus.armed),        32'd0);
        check_val({tag, "_err"},   32'(bus.cfg_err),      32'd0);
        check_val({tag, "_oeb"},   32'(bus.io_oeb),       32'd0);
    endtask

    int exp_sat;

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_pattern = 8'd0; bus.cfg_len = 4'd0; bus.cfg_overlap = 1'b0;
        bus.in_valid = 1'b0; bus.sequence_in = 1'b0; bus.cnt_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // 1: six-bit pattern, single pulse after the sixth bit.
        npulse = 0;
        cfg(8'b0010_1011, 4'd6, 1'b1);
        stream(8'b0010_1011, 6);
        gap(); gap();
        check_val("t1_pulses", npulse, 1);

        // 2: overlapping vs non-overlapping on 1,0,1,0,1.
        clr_cnt();
        npulse = 0;
        cfg(8'b0000_0101, 4'd3, 1'b1);
        stream(8'b0001_0101, 5);
        check_val("t2_ovl_pulses", npulse, 2);
        clr_cnt();
        npulse = 0;
        cfg(8'b0000_0101, 4'd3, 1'b0);
        stream(8'b0001_0101, 5);
        check_val("t2_novl_pulses", npulse, 1);

        // 3: invalid gaps inside a partial match.
        clr_cnt();
        npulse = 0;
        cfg(8'b0010_1011, 4'd6, 1'b1);
        bit_in(1'b1); bit_in(1'b0);
        gap(); gap(); gap();
        check_val("t3_gap_pulses", npulse, 0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        check_val("t3_pulses", npulse, 1);

        // 4: invalid length 0, then 9, then a valid config; cfg with in_valid same cycle.
        npulse = 0;
        cfg(8'b0000_0001, 4'd0, 1'b1);
        check_val("t4_armed", 32'(bus.armed), 32'd0);
        check_val("t4_err",   32'(bus.cfg_err), 32'd1);
        stream(8'b1111_1111, 8);
        cfg(8'b0000_0001, 4'd9, 1'b1);
        stream(8'b0101_0101, 8);
        check_val("t4_pulses", npulse, 0);
        drive(1'b1, 8'b0000_0011, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("t4_armed2", 32'(bus.armed), 32'd1);
        check_val("t4_err2",   32'(bus.cfg_err), 32'd0);
        bit_in(1'b1);
        check_val("t4_discard", npulse, 0);
        bit_in(1'b1);
        check_val("t4_after", npulse, 1);

        // 5: len 1, five matches saturate the 2-bit counter; clear with a match gives 1.
        clr_cnt();
        cfg(8'b0000_0001, 4'd1, 1'b0);
        stream(8'b0001_1111, 5);
`ifdef IIITB_PDET_CNT_EN
        exp_sat = 3;
`else
        exp_sat = 0;
`endif
        check_val("t5_sat", 32'(bus.match_count), 32'(exp_sat));
        drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_val("t5_clr_inc", 32'(bus.match_count), 32'(exp_sat == 3 ? 1 : 0));
        bit_in(1'b0);

        // 6: reset in the middle of a partial match.
        npulse = 0;
        cfg(8'b0010_1011, 4'd6, 1'b1);
        stream(8'b0000_1010, 4);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_all_zero("t6_async");
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        bit_in(1'b1); bit_in(1'b1);
        check_val("t6_pulses", npulse, 0);
        check_all_zero("t6_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
